atcaxi2tluh500_id_alloc: RTL and testbench
==========================================

# atcaxi2tluh500_id_alloc

Parametrised free-slot allocator for the AXI-to-TL-UH bridge. It tracks N outstanding-transaction slots (source IDs) in a busy vector and offers one free slot per cycle through a valid/ready handshake. Slots are released through a separate free port. It generalises the first-zero (trailing-ones) search into a registered allocator with lowest-first or round-robin selection, occupancy count, and error reporting.

## Interface
- N, 4: number of slots; 2 <= N <= 256, power of two not required.
- RR, 0: selection mode; 0 = lowest free index, 1 = round-robin starting after the last allocated index.
- W (localparam): max(1, $clog2(N)), ID width.

- aclk  input  1  clock; one clock domain, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- alloc_valid  output  1  a free slot is offered on alloc_id.
- alloc_ready  input  1  consumer takes the offered slot.
- alloc_id  output  W  offered slot index.
- free_valid  input  1  release request.
- free_id  input  W  slot to release.
- busy  output  N  registered busy vector.
- busy_cnt  output  W+1  number of busy slots, 0..N.
- full  output  1  busy_cnt == N.
- empty  output  1  busy_cnt == 0.
- free_err  output  1  sticky illegal-free flag.
- err_clr  input  1  clears free_err.

## Operation
- Allocation fires when alloc_valid & alloc_ready. On fire, busy[alloc_id] is set next cycle and the last-allocated pointer is updated (ptr <= alloc_id).
- Free is legal when free_id < N and busy[free_id] == 1, judged on the current registered busy. A legal free clears that bit next cycle. An illegal free is ignored and sets free_err.
- busy_nxt = (busy | alloc_onehot) & ~free_onehot, using legal events only. busy_cnt_nxt = busy_cnt + fire − legal_free.
- Selection is computed from busy_nxt and ptr_nxt, then registered into alloc_valid and alloc_id:
  - RR=0: index of the lowest zero bit of busy_nxt, computed as ~b & (b+1) followed by onehot-to-binary.
  - RR=1: rotate busy_nxt right by (ptr_nxt+1) mod N, find the lowest zero, then add (ptr_nxt+1) and subtract N if the result is >= N.
  - alloc_valid_nxt = ~&busy_nxt. When no slot is free, alloc_id holds its previous value.
- Simultaneous alloc fire and legal free of a different slot: both take effect and busy_cnt is unchanged. The freed slot can be offered from the next cycle.
- free_id == alloc_id in a fire cycle: the slot is not busy, so the free is illegal. free_err is set and the alloc proceeds.
- free_err: set by an illegal free, cleared by err_clr. Set has priority over clear in the same cycle.
- full and empty are registered alongside busy_cnt.

## Timing
- Reset values: busy=0, busy_cnt=0, empty=1, full=0, alloc_valid=0, alloc_id=0, free_err=0, ptr=N−1 (so RR mode first offers 0).
- First cycle after reset deasserts: alloc_valid=1, alloc_id=0 in both modes.
- Latency:
  - A fire updates busy, busy_cnt and the offer on the next edge, so back-to-back allocation at 1 per cycle is supported.
  - A freed slot is visible in busy next cycle and can be offered that same next cycle.
- alloc_id stays stable while alloc_valid=1 and no fire or free occurs.
- Reset asserted mid-operation returns all state to reset values on the next edge, regardless of alloc or free inputs in that cycle.
- No combinational path from any input to any output.

## Test plan
- N=4, RR=0, alloc_ready held 1 from reset release: fires with ids 0,1,2,3 on consecutive cycles, then full=1, alloc_valid=0, busy=4'b1111, busy_cnt=4.
- From full, free_id=2: next cycle busy=4'b1011, alloc_valid=1, alloc_id=2. Free 0 then free 1: offer becomes 0.
- N=4, RR=1:
  - alloc 0, alloc 1, free 0, alloc: the third allocation gets 2, not 0.
  - Allocate up to 3, then free 0: the next offer wraps to 0.
- N=5, RR=1 (non-power-of-two): allocate 0..4, free 1 and 3: the next offers are 1 then 3. The rotated index never reaches 5.
- N=4, busy=4'b0011, same cycle fire on id 2 and free_id=0: next busy=4'b0110, busy_cnt=2, alloc_id=0 (RR=0).
- Illegal free, then reset mid-run:
  - free_id=3 while busy[3]=0: free_err=1 and busy unchanged.
  - err_clr clears free_err.
  - err_clr in the same cycle as another illegal free leaves free_err=1.
  - Reset with busy=4'b1111: next cycle all outputs equal their reset values.

Source files
------------

// File: rtl/atcaxi2tluh500_id_alloc.sv
// Free-slot (source ID) allocator: busy tracking, registered offer with
// lowest-first or round-robin selection, occupancy count and illegal-free flag.
module atcaxi2tluh500_id_alloc #(
   parameter int unsigned N  = 4,
   parameter bit          RR = 1'b0
) (
   input  logic                                    aclk,
   input  logic                                    reset,
   output logic                                    alloc_valid,
   input  logic                                    alloc_ready,
   output logic [((N > 2) ? $clog2(N) : 1)-1:0]    alloc_id,
   input  logic                                    free_valid,
   input  logic [((N > 2) ? $clog2(N) : 1)-1:0]    free_id,
   output logic [N-1:0]                            busy,
   output logic [((N > 2) ? $clog2(N) : 1):0]      busy_cnt,
   output logic                                    full,
   output logic                                    empty,
   output logic                                    free_err,
   input  logic                                    err_clr
);

   localparam int unsigned W  = (N > 2) ? $clog2(N) : 1;
   localparam int unsigned CW = W + 1;

   logic [N-1:0]  busy_q,  busy_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic          full_q,  full_d;
   logic          empty_q, empty_d;
   logic          valid_q, valid_d;
   logic [W-1:0]  id_q,    id_d;
   logic [W-1:0]  ptr_q,   ptr_d;
   logic          err_q,   err_d;

   // Index of the lowest zero bit: isolate it with ~b & (b+1), then encode.
   function automatic logic [W-1:0] lowest_zero(input logic [N-1:0] b);
      logic [N-1:0] oh;
      logic [W-1:0] idx;
      oh  = ~b & (b + N'(1));
      idx = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (oh[i]) idx = W'(i);
      end
      return idx;
   endfunction

   // Next-state: legal events, busy/count update, next offer selection.
   always_comb begin
      logic          fire;
      logic          free_hit;
      logic          free_legal;
      logic [N-1:0]  alloc_oh;
      logic [N-1:0]  free_oh;
      logic [W-1:0]  start;
      logic [N-1:0]  rot;
      logic [W-1:0]  rot_idx;
      logic [CW-1:0] sum;
      logic [W-1:0]  sel;

      fire       = valid_q & alloc_ready;
      free_hit   = 1'b0;
      alloc_oh   = '0;
      free_oh    = '0;
      start      = '0;
      rot        = '0;
      rot_idx    = '0;
      sum        = '0;
      sel        = '0;

      // free_id may exceed N-1 when N is not a power of two; decode by loop.
      for (int unsigned i = 0; i < N; i++) begin
         if (free_id == W'(i) && busy_q[i]) free_hit = 1'b1;
         if (free_id == W'(i)) free_oh[i] = 1'b1;
         if (id_q == W'(i)) alloc_oh[i] = fire;
      end
      free_legal = free_valid & free_hit;
      if (!free_legal) free_oh = '0;

      busy_d  = (busy_q | alloc_oh) & ~free_oh;
      cnt_d   = cnt_q + CW'(fire) - CW'(free_legal);
      full_d  = (cnt_d == CW'(N));
      empty_d = (cnt_d == '0);
      ptr_d   = fire ? id_q : ptr_q;

      if (RR) begin
         start   = (ptr_d == W'(N - 1)) ? '0 : ptr_d + W'(1);
         rot     = N'({busy_d, busy_d} >> start);
         rot_idx = lowest_zero(rot);
         sum     = CW'(rot_idx) + CW'(start);
         if (sum >= CW'(N)) sum = sum - CW'(N);
         sel     = W'(sum);
      end else begin
         sel     = lowest_zero(busy_d);
      end

      valid_d = ~&busy_d;
      id_d    = valid_d ? sel : id_q;

      // Set wins over clear.
      err_d = err_q;
      if (err_clr) err_d = 1'b0;
      if (free_valid && !free_legal) err_d = 1'b1;
   end

   // State registers with synchronous reset.
   always_ff @(posedge aclk) begin
      if (reset) begin
         busy_q  <= '0;
         cnt_q   <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         valid_q <= 1'b0;
         id_q    <= '0;
         ptr_q   <= W'(N - 1);
         err_q   <= 1'b0;
      end else begin
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
         full_q  <= full_d;
         empty_q <= empty_d;
         valid_q <= valid_d;
         id_q    <= id_d;
         ptr_q   <= ptr_d;
         err_q   <= err_d;
      end
   end

   assign alloc_valid = valid_q;
   assign alloc_id    = id_q;
   assign busy        = busy_q;
   assign busy_cnt    = cnt_q;
   assign full        = full_q;
   assign empty       = empty_q;
   assign free_err    = err_q;

endmodule

// File: tb/tb_atcaxi2tluh500_id_alloc.sv
// Directed bench for the ID allocator: three instances (N=4 lowest-first,
// N=4 round-robin, N=5 round-robin) driven one at a time.
module tb_atcaxi2tluh500_id_alloc;

   logic       clk;
   logic       rst [3];
   logic       rdy [3];
   logic       fv  [3];
   logic       clr [3];
   logic [2:0] fid [3];

   logic       v0, v1, v2;
   logic [1:0] id0, id1;
   logic [2:0] id2;
   logic [3:0] busy0, busy1;
   logic [4:0] busy2;
   logic [2:0] cnt0, cnt1;
   logic [3:0] cnt2;
   logic       full0, full1, full2, empty0, empty1, empty2, err0, err1, err2;

   logic [7:0] o_id [3];
   logic [7:0] o_busy [3];
   logic [7:0] o_cnt [3];
   logic       o_v [3];
   logic       o_full [3];
   logic       o_empty [3];
   logic       o_err [3];

   int         n_vec;
   int         n_err;
   logic [7:0] exp_q [$];

   atcaxi2tluh500_id_alloc #(.N(4), .RR(1'b0)) u_lo4 (
      .aclk(clk), .reset(rst[0]), .alloc_valid(v0), .alloc_ready(rdy[0]), .alloc_id(id0),
      .free_valid(fv[0]), .free_id(fid[0][1:0]), .busy(busy0), .busy_cnt(cnt0),
      .full(full0), .empty(empty0), .free_err(err0), .err_clr(clr[0]));

   atcaxi2tluh500_id_alloc #(.N(4), .RR(1'b1)) u_rr4 (
      .aclk(clk), .reset(rst[1]), .alloc_valid(v1), .alloc_ready(rdy[1]), .alloc_id(id1),
      .free_valid(fv[1]), .free_id(fid[1][1:0]), .busy(busy1), .busy_cnt(cnt1),
      .full(full1), .empty(empty1), .free_err(err1), .err_clr(clr[1]));

   atcaxi2tluh500_id_alloc #(.N(5), .RR(1'b1)) u_rr5 (
      .aclk(clk), .reset(rst[2]), .alloc_valid(v2), .alloc_ready(rdy[2]), .alloc_id(id2),
      .free_valid(fv[2]), .free_id(fid[2]), .busy(busy2), .busy_cnt(cnt2),
      .full(full2), .empty(empty2), .free_err(err2), .err_clr(clr[2]));

   assign o_id[0] = 8'(id0);   assign o_id[1] = 8'(id1);   assign o_id[2] = 8'(id2);
   assign o_busy[0] = 8'(busy0); assign o_busy[1] = 8'(busy1); assign o_busy[2] = 8'(busy2);
   assign o_cnt[0] = 8'(cnt0); assign o_cnt[1] = 8'(cnt1); assign o_cnt[2] = 8'(cnt2);
   assign o_v[0] = v0;         assign o_v[1] = v1;         assign o_v[2] = v2;
   assign o_full[0] = full0;   assign o_full[1] = full1;   assign o_full[2] = full2;
   assign o_empty[0] = empty0; assign o_empty[1] = empty1; assign o_empty[2] = empty2;
   assign o_err[0] = err0;     assign o_err[1] = err1;     assign o_err[2] = err2;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // One clock of stimulus on instance k; a fire pops the scoreboard.
   task automatic cyc(input int k, input logic r, input logic f,
                      input logic [2:0] id, input logic c);
      rdy[k] = r; fv[k] = f; fid[k] = id; clr[k] = c;
      if (r && o_v[k]) begin
         if (exp_q.size() == 0) chk("unexpected_fire", o_id[k], 8'hFF);
         else                   chk("fire_id", o_id[k], exp_q.pop_front());
      end
      @(posedge clk); #1;
      rdy[k] = 1'b0; fv[k] = 1'b0; clr[k] = 1'b0; fid[k] = '0;
   endtask

   task automatic chk_reset(input int k);
      chk("rst_valid", 8'(o_v[k]), 8'd0);
      chk("rst_id",    o_id[k],    8'd0);
      chk("rst_busy",  o_busy[k],  8'd0);
      chk("rst_cnt",   o_cnt[k],   8'd0);
      chk("rst_empty", 8'(o_empty[k]), 8'd1);
      chk("rst_full",  8'(o_full[k]),  8'd0);
      chk("rst_err",   8'(o_err[k]),   8'd0);
   endtask

   initial begin
      clk = 1'b0; n_vec = 0; n_err = 0;
      for (int i = 0; i < 3; i++) begin
         rst[i] = 1'b1; rdy[i] = 1'b0; fv[i] = 1'b0; clr[i] = 1'b0; fid[i] = '0;
      end
      repeat (2) @(posedge clk);
      #1;

      // ---- N=4, lowest-first ----
      rst[0] = 1'b0;
      chk_reset(0);
      cyc(0, 0, 0, 0, 0);
      chk("lo_first_valid", 8'(o_v[0]), 8'd1);
      chk("lo_first_id", o_id[0], 8'd0);
      for (int i = 0; i < 4; i++) exp_q.push_back(8'(i));
      for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0);
      chk("lo_full", 8'(o_full[0]), 8'd1);
      chk("lo_full_valid", 8'(o_v[0]), 8'd0);
      chk("lo_full_busy", o_busy[0], 8'hF);
      chk("lo_full_cnt", o_cnt[0], 8'd4);
      chk("lo_full_empty", 8'(o_empty[0]), 8'd0);
      cyc(0, 0, 1, 2, 0);
      chk("lo_free2_busy", o_busy[0], 8'hB);
      chk("lo_free2_valid", 8'(o_v[0]), 8'd1);
      chk("lo_free2_id", o_id[0], 8'd2);
      cyc(0, 0, 1, 0, 0);
      chk("lo_free0_id", o_id[0], 8'd0);
      cyc(0, 0, 1, 1, 0);
      chk("lo_free1_id", o_id[0], 8'd0);
      chk("lo_free1_busy", o_busy[0], 8'h8);
      chk("lo_free1_cnt", o_cnt[0], 8'd1);
      cyc(0, 0, 0, 0, 0);
      chk("lo_stable_id", o_id[0], 8'd0);
      cyc(0, 0, 1, 3, 0);
      chk("lo_empty", 8'(o_empty[0]), 8'd1);
      exp_q.push_back(8'd0); exp_q.push_back(8'd1);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      chk("lo_pre_busy", o_busy[0], 8'h3);
      chk("lo_pre_id", o_id[0], 8'd2);
      exp_q.push_back(8'd2);
      cyc(0, 1, 1, 0, 0);
      chk("lo_simul_busy", o_busy[0], 8'h6);
      chk("lo_simul_cnt", o_cnt[0], 8'd2);
      chk("lo_simul_id", o_id[0], 8'd0);
      cyc(0, 0, 1, 3, 0);
      chk("lo_illegal_err", 8'(o_err[0]), 8'd1);
      chk("lo_illegal_busy", o_busy[0], 8'h6);
      cyc(0, 0, 0, 0, 1);
      chk("lo_clr_err", 8'(o_err[0]), 8'd0);
      cyc(0, 0, 1, 3, 1);
      chk("lo_setclr_err", 8'(o_err[0]), 8'd1);
      cyc(0, 0, 0, 0, 1);
      chk("lo_clr2_err", 8'(o_err[0]), 8'd0);
      exp_q.push_back(8'd0);
      cyc(0, 1, 1, 0, 0);
      chk("lo_selffree_err", 8'(o_err[0]), 8'd1);
      chk("lo_selffree_busy", o_busy[0], 8'h7);
      chk("lo_selffree_cnt", o_cnt[0], 8'd3);
      exp_q.push_back(8'd3);
      cyc(0, 1, 0, 0, 0);
      chk("lo_refill_busy", o_busy[0], 8'hF);
      rst[0] = 1'b1;
      cyc(0, 1, 1, 1, 0);
      chk_reset(0);
      rst[0] = 1'b0;

      // ---- N=4, round-robin ----
      rst[1] = 1'b0;
      chk_reset(1);
      cyc(1, 0, 0, 0, 0);
      chk("rr4_first_valid", 8'(o_v[1]), 8'd1);
      chk("rr4_first_id", o_id[1], 8'd0);
      exp_q.push_back(8'd0); exp_q.push_back(8'd1);
      cyc(1, 1, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
      cyc(1, 0, 1, 0, 0);
      chk("rr4_after_free0_id", o_id[1], 8'd2);
      exp_q.push_back(8'd2); exp_q.push_back(8'd3);
      cyc(1, 1, 0, 0, 0);
      chk("rr4_third_next", o_id[1], 8'd3);
      cyc(1, 1, 0, 0, 0);
      chk("rr4_wrap_id", o_id[1], 8'd0);
      chk("rr4_busy", o_busy[1], 8'hE);
      exp_q.push_back(8'd0);
      cyc(1, 1, 0, 0, 0);
      chk("rr4_full", 8'(o_full[1]), 8'd1);
      cyc(1, 0, 1, 0, 0);
      chk("rr4_free0_valid", 8'(o_v[1]), 8'd1);
      chk("rr4_free0_id", o_id[1], 8'd0);

      // ---- N=5, round-robin ----
      rst[2] = 1'b0;
      chk_reset(2);
      cyc(2, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) exp_q.push_back(8'(i));
      for (int i = 0; i < 5; i++) cyc(2, 1, 0, 0, 0);
      chk("rr5_full", 8'(o_full[2]), 8'd1);
      chk("rr5_busy", o_busy[2], 8'h1F);
      chk("rr5_cnt", o_cnt[2], 8'd5);
      chk("rr5_valid", 8'(o_v[2]), 8'd0);
      cyc(2, 0, 1, 1, 0);
      chk("rr5_free1_id", o_id[2], 8'd1);
      cyc(2, 0, 1, 3, 0);
      chk("rr5_free3_id", o_id[2], 8'd1);
      chk("rr5_free3_busy", o_busy[2], 8'h15);
      exp_q.push_back(8'd1);
      cyc(2, 1, 0, 0, 0);
      chk("rr5_next_id", o_id[2], 8'd3);
      exp_q.push_back(8'd3);
      cyc(2, 1, 0, 0, 0);
      chk("rr5_refull", 8'(o_full[2]), 8'd1);
      cyc(2, 0, 1, 5, 0);
      chk("rr5_oob_err", 8'(o_err[2]), 8'd1);
      chk("rr5_oob_busy", o_busy[2], 8'h1F);

      chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
